// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the 2-way set-associative data cache.
package cache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTag,
    StWb,
    StFill,
    StResp
  } state_e;

  function automatic int unsigned calc_off_w(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned calc_idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned calc_tag_w(input int unsigned addr_w, input int unsigned sets,
                                             input int unsigned words);
    return addr_w - 2 - calc_off_w(words) - calc_idx_w(sets);
  endfunction

  function automatic logic [63:0] addr_field(input logic [63:0] addr, input int unsigned lsb,
                                             input int unsigned width);
    return (addr >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_off(input logic [63:0] addr, input int unsigned words);
    return addr_field(addr, 2, calc_off_w(words));
  endfunction

  function automatic logic [63:0] addr_idx(input logic [63:0] addr, input int unsigned sets,
                                           input int unsigned words);
    return addr_field(addr, 2 + calc_off_w(words), calc_idx_w(sets));
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int unsigned addr_w,
                                           input int unsigned sets, input int unsigned words);
    return addr_field(addr, 2 + calc_off_w(words) + calc_idx_w(sets),
                      calc_tag_w(addr_w, sets, words));
  endfunction

endpackage

// File: rtl/param_assoc_cache_if.sv
// CPU-side and memory-side handshake signals of the cache, grouped as one bundle.
interface param_assoc_cache_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_way.sv
// One way of the cache: valid/dirty/tag per set plus the line data, with combinational lookup.
module cache_way
  import cache_pkg::*;
#(
  parameter int unsigned   ADDR_W = 32,
  parameter int unsigned   DATA_W = 32,
  parameter int unsigned   SETS   = 16,
  parameter int unsigned   WORDS  = 4,
  localparam int unsigned  IDX_W  = calc_idx_w(SETS),
  localparam int unsigned  OFF_B  = (calc_off_w(WORDS) > 0) ? calc_off_w(WORDS) : 1,
  localparam int unsigned  TAG_W  = calc_tag_w(ADDR_W, SETS, WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [OFF_B-1:0]  i_off,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_hit,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [TAG_W-1:0]  o_tag,
  output logic [DATA_W-1:0] o_rdata,
  input  logic              i_data_we,
  input  logic [OFF_B-1:0]  i_data_off,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_fill_done,
  input  logic              i_set_dirty
);

  logic [SETS-1:0]   r_valid;
  logic [SETS-1:0]   r_dirty;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [DATA_W-1:0] r_data [SETS][WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_fill_done) begin
        r_valid[i_idx] <= 1'b1;
        r_dirty[i_idx] <= 1'b0;
      end
      if (i_set_dirty) begin
        r_dirty[i_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays are deliberately left out of reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (i_fill_done) begin
      r_tag[i_idx] <= i_tag;
    end
    if (i_data_we) begin
      r_data[i_idx][i_data_off] <= i_data;
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_rdata = r_data[i_idx][i_off];
  assign o_hit   = r_valid[i_idx] && (r_tag[i_idx] == i_tag);

endmodule

// File: rtl/param_assoc_cache.sv
// 2-way set-associative write-back/write-allocate data cache with LRU and hit/miss counters.
module param_assoc_cache
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SETS   = 16,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  param_assoc_cache_if.slave   bus,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     miss_count
);

  localparam int unsigned OFF_W = calc_off_w(WORDS);
  localparam int unsigned IDX_W = calc_idx_w(SETS);
  localparam int unsigned TAG_W = calc_tag_w(ADDR_W, SETS, WORDS);
  localparam int unsigned OFF_B = (OFF_W > 0) ? OFF_W : 1;

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic              r_refilled;
  logic              r_victim;
  logic              r_hit_way;
  logic [SETS-1:0]   r_lru;
  logic [OFF_B-1:0]  r_word;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cpu_ready;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [OFF_B-1:0]  w_off;
  logic [OFF_B-1:0]  w_rd_off;
  logic [1:0]        w_hit_v, w_valid, w_dirty;
  logic [1:0]        w_data_we, w_fill_done, w_set_dirty;
  logic [TAG_W-1:0]  w_way_tag   [2];
  logic [DATA_W-1:0] w_way_rdata [2];
  logic [OFF_B-1:0]  w_wr_off;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_hit, w_hit_way;
  logic              w_victim_sel, w_victim_dirty;
  logic              w_mem_fire, w_last;
  logic [TAG_W-1:0]  w_vic_tag;
  logic [DATA_W-1:0] w_vic_rdata;
  logic [ADDR_W-1:0] w_wb_addr, w_fill_addr;

  assign w_tag = TAG_W'(addr_tag(64'(r_addr), ADDR_W, SETS, WORDS));
  assign w_idx = IDX_W'(addr_idx(64'(r_addr), SETS, WORDS));
  assign w_off = OFF_B'(addr_off(64'(r_addr), WORDS));

  // During write-back the ways are read at the burst word rather than the CPU word.
  assign w_rd_off = (r_state == StWb) ? r_word : w_off;

  for (genvar g = 0; g < 2; g++) begin : g_way
    cache_way #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .SETS   (SETS),
      .WORDS  (WORDS)
    ) u_way (
      .clk        (clk),
      .rst        (rst),
      .i_idx      (w_idx),
      .i_off      (w_rd_off),
      .i_tag      (w_tag),
      .o_hit      (w_hit_v[g]),
      .o_valid    (w_valid[g]),
      .o_dirty    (w_dirty[g]),
      .o_tag      (w_way_tag[g]),
      .o_rdata    (w_way_rdata[g]),
      .i_data_we  (w_data_we[g]),
      .i_data_off (w_wr_off),
      .i_data     (w_wr_data),
      .i_fill_done(w_fill_done[g]),
      .i_set_dirty(w_set_dirty[g])
    );
  end

  assign w_hit          = |w_hit_v;
  assign w_hit_way      = w_hit_v[1];
  assign w_victim_sel   = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : r_lru[w_idx]);
  assign w_victim_dirty = w_valid[w_victim_sel] && w_dirty[w_victim_sel];
  assign w_mem_fire     = r_mem_req && bus.mem_ack;
  assign w_last         = (r_word == OFF_B'(WORDS - 1));
  assign w_vic_tag      = w_way_tag[r_victim];
  assign w_vic_rdata    = w_way_rdata[r_victim];

  assign w_wb_addr   = ADDR_W'((64'(w_vic_tag) << (IDX_W + OFF_W + 2)) |
                               (64'(w_idx) << (OFF_W + 2)) | (64'(r_word) << 2));
  assign w_fill_addr = ADDR_W'((64'(w_tag) << (IDX_W + OFF_W + 2)) |
                               (64'(w_idx) << (OFF_W + 2)) | (64'(r_word) << 2));

  always_comb begin
    w_data_we   = '0;
    w_fill_done = '0;
    w_set_dirty = '0;
    w_wr_off    = r_word;
    w_wr_data   = bus.mem_rdata;
    if (r_state == StFill && w_mem_fire) begin
      w_data_we[r_victim]   = 1'b1;
      w_fill_done[r_victim] = w_last;
    end
    if (r_state == StResp && r_we) begin
      w_data_we[r_hit_way]   = 1'b1;
      w_set_dirty[r_hit_way] = 1'b1;
      w_wr_off               = w_off;
      w_wr_data              = r_wdata;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (bus.cpu_req) w_state_d = StTag;
      StTag:   w_state_d = w_hit ? StResp : (w_victim_dirty ? StWb : StFill);
      StWb:    if (w_mem_fire && w_last) w_state_d = StFill;
      StFill:  if (w_mem_fire && w_last) w_state_d = StTag;
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_refilled  <= 1'b0;
      r_victim    <= 1'b0;
      r_hit_way   <= 1'b0;
      r_lru       <= '0;
      r_word      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_ready <= 1'b0;
      r_cpu_rdata <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_cpu_ready <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.cpu_req) begin
            r_addr     <= bus.cpu_addr;
            r_we       <= bus.cpu_we;
            r_wdata    <= bus.cpu_wdata;
            r_refilled <= 1'b0;
          end
        end
        StTag: begin
          if (w_hit) begin
            r_hit_way   <= w_hit_way;
            r_cpu_ready <= 1'b1;
            r_cpu_rdata <= w_way_rdata[w_hit_way];
            if (!r_refilled && r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
          end else begin
            r_victim <= w_victim_sel;
            r_word   <= '0;
            if (!r_refilled && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
          end
        end
        StWb, StFill: begin
          // Request drops on ack and re-rises next cycle, leaving one idle cycle per word.
          if (r_mem_req) begin
            if (bus.mem_ack) begin
              r_mem_req <= 1'b0;
              r_mem_we  <= 1'b0;
              r_word    <= w_last ? '0 : r_word + OFF_B'(1);
              if (r_state == StFill && w_last) r_refilled <= 1'b1;
            end
          end else begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= (r_state == StWb);
            r_mem_addr  <= (r_state == StWb) ? w_wb_addr : w_fill_addr;
            r_mem_wdata <= (r_state == StWb) ? w_vic_rdata : '0;
          end
        end
        StResp: begin
          r_lru[w_idx] <= ~r_hit_way;
        end
        default: ;
      endcase
    end
  end

  assign bus.cpu_ready = r_cpu_ready;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign hit_count     = r_hit_cnt;
  assign miss_count    = r_miss_cnt;

endmodule

// File: tb/tb_param_assoc_cache.sv
// Directed bench for param_assoc_cache: SETS=4, WORDS=4, CNT_W=4, memory ack latency 3.
module tb_param_assoc_cache;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  param_assoc_cache_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  logic [3:0] hit_count, miss_count;

  param_assoc_cache #(
    .ADDR_W(32),
    .DATA_W(32),
    .SETS  (4),
    .WORDS (4),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  logic [31:0] mem [256];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  logic        log_we   [$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Word memory: ack three cycles into each request, one-cycle ack pulse.
  initial begin : mem_model
    int cnt;
    cnt = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
    mem[16] = 32'd1;
    mem[17] = 32'd2;
    mem[18] = 32'd3;
    mem[19] = 32'd4;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req) begin
        cnt++;
        if (cnt == 3) begin
          cnt = 0;
          log_addr.push_back(bus.mem_addr);
          log_we.push_back(bus.mem_we);
          log_data.push_back(bus.mem_wdata);
          if (bus.mem_we) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
          else bus.mem_rdata = mem[bus.mem_addr[9:2]];
          bus.mem_ack = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int cyc);
    logic got;
    got = 1'b0;
    rd = '0;
    cyc = 0;
    bus.cpu_we = we;
    bus.cpu_addr = addr;
    bus.cpu_wdata = wd;
    bus.cpu_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.cpu_ready) begin
        rd = bus.cpu_rdata;
        got = 1'b1;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    check("cpu_ready_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] rd;
    logic [31:0] wb_exp [4];
    int cyc;
    int base;
    logic found;
    wb_exp[0] = 32'd1;
    wb_exp[1] = 32'hDEAD_BEEF;
    wb_exp[2] = 32'd3;
    wb_exp[3] = 32'd4;

    rst = 1'b1;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_hit", 32'(hit_count), 32'd0);
    check("rst_miss", 32'(miss_count), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Cold miss: line 0x40 refilled into way0.
    base = log_addr.size();
    access(1'b0, 32'h40, 32'h0, rd, cyc);
    check("cold_rdata", rd, 32'd1);
    check("cold_txn_cnt", 32'(log_addr.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("cold_addr", log_addr[base+k], 32'h40 + 32'(k * 4));
      check("cold_is_read", 32'(log_we[base+k]), 32'd0);
    end
    check("cold_miss", 32'(miss_count), 32'd1);
    check("cold_hit", 32'(hit_count), 32'd0);

    base = log_addr.size();
    access(1'b0, 32'h48, 32'h0, rd, cyc);
    check("hit_latency", 32'(cyc), 32'd2);
    check("hit_rdata", rd, 32'd3);
    check("hit_no_traffic", 32'(log_addr.size() - base), 32'd0);
    check("hit_count1", 32'(hit_count), 32'd1);

    access(1'b1, 32'h44, 32'hDEAD_BEEF, rd, cyc);
    check("store_latency", 32'(cyc), 32'd2);
    access(1'b0, 32'h44, 32'h0, rd, cyc);
    check("store_readback", rd, 32'hDEAD_BEEF);
    check("store_no_traffic", 32'(log_addr.size() - base), 32'd0);
    check("hit_count3", 32'(hit_count), 32'd3);

    // Second line of set 0 goes to the empty way1.
    base = log_addr.size();
    access(1'b0, 32'h140, 32'h0, rd, cyc);
    check("way1_rdata", rd, 32'hA000_0050);
    check("way1_txn_cnt", 32'(log_addr.size() - base), 32'd4);
    check("way1_miss", 32'(miss_count), 32'd2);
    access(1'b0, 32'h144, 32'h0, rd, cyc);
    check("touch_rdata", rd, 32'hA000_0051);

    // Both ways valid; way0 is LRU and dirty -> write back then refill.
    base = log_addr.size();
    access(1'b0, 32'h240, 32'h0, rd, cyc);
    check("evict_rdata", rd, 32'hA000_0090);
    check("evict_txn_cnt", 32'(log_addr.size() - base), 32'd8);
    for (int k = 0; k < 4; k++) begin
      check("wb_addr", log_addr[base+k], 32'h40 + 32'(k * 4));
      check("wb_is_write", 32'(log_we[base+k]), 32'd1);
      check("wb_data", log_data[base+k], wb_exp[k]);
      check("refill_addr", log_addr[base+4+k], 32'h240 + 32'(k * 4));
      check("refill_is_read", 32'(log_we[base+4+k]), 32'd0);
    end
    check("mem_44_written", mem[17], 32'hDEAD_BEEF);
    check("evict_miss", 32'(miss_count), 32'd3);
    check("evict_hit", 32'(hit_count), 32'd4);

    base = log_addr.size();
    access(1'b0, 32'h140, 32'h0, rd, cyc);
    check("survivor_rdata", rd, 32'hA000_0050);
    check("survivor_no_traffic", 32'(log_addr.size() - base), 32'd0);

    // Reset while the second refill word is outstanding.
    base = log_addr.size();
    found = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 32'h80;
    bus.cpu_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.mem_req && !bus.mem_ack && log_addr.size() == base + 1) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_burst_reached", 32'(found), 32'd1);
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    @(posedge clk);
    #1;
    check("abort_mem_req", 32'(bus.mem_req), 32'd0);
    check("abort_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    rst = 1'b0;
    check("abort_hit", 32'(hit_count), 32'd0);
    check("abort_miss", 32'(miss_count), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("abort_quiet_req", 32'(bus.mem_req), 32'd0);
    check("abort_quiet_txn", 32'(log_addr.size() - base), 32'd1);

    base = log_addr.size();
    access(1'b0, 32'h40, 32'h0, rd, cyc);
    check("post_rst_rdata", rd, 32'd1);
    check("post_rst_txn_cnt", 32'(log_addr.size() - base), 32'd4);
    check("post_rst_miss", 32'(miss_count), 32'd1);
    check("post_rst_hit", 32'(hit_count), 32'd0);

    // 4-bit hit counter saturates at 0xF.
    for (int i = 1; i <= 17; i++) begin
      access(1'b0, 32'h44, 32'h0, rd, cyc);
      check("sat_rdata", rd, 32'hDEAD_BEEF);
      check("sat_hit", 32'(hit_count), (i > 15) ? 32'd15 : 32'(i));
    end
    check("sat_miss", 32'(miss_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_assoc_cache.md
Name: param_assoc_cache

Overview:
- Parametrised 2-way set-associative, write-back, write-allocate data cache for the MIPS datapath.
- Successor to the fixed single-configuration cache. Adds configurable sets and line size, LRU replacement, dirty-line write-back and hit/miss counters.
- Sits between the MEM stage (CPU port) and main memory (word-serial memory port with ack handshake).

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width. Fixed at 32; byte offset is 2 bits.
- SETS, 16, number of sets. Power of 2, 2..256.
- WORDS, 4, words per line. Power of 2, 1..16.
- CNT_W, 16, width of the hit and miss counters.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous active-high reset.
- cpu_req, in, 1, access request. Must be held with addr/we/wdata stable until cpu_ready.
- cpu_we, in, 1, 1 = store word, 0 = load word.
- cpu_addr, in, ADDR_W, byte address. Bits [1:0] are ignored.
- cpu_wdata, in, DATA_W, store data.
- cpu_rdata, out, DATA_W, load data. Valid only while cpu_ready=1.
- cpu_ready, out, 1, one-cycle completion pulse.
- mem_req, out, 1, memory word request. Held until mem_ack.
- mem_we, out, 1, memory write.
- mem_addr, out, ADDR_W, word-aligned memory address.
- mem_wdata, out, DATA_W, write-back data.
- mem_rdata, in, DATA_W, refill data. Valid with mem_ack.
- mem_ack, in, 1, one-cycle memory completion.
- hit_count, out, CNT_W, saturating count of hits.
- miss_count, out, CNT_W, saturating count of misses.

Behaviour:
- Address split: offset = addr[OFF_W+1:2] with OFF_W = log2(WORDS); index = next IDX_W = log2(SETS) bits; tag = remaining upper bits.
- Per way and per set: valid, dirty, tag, and WORDS data words. Per set: one LRU bit naming the way to evict next.
- Reset (rst=1 at a clk edge):
  - All valid, dirty and LRU bits are cleared.
  - Counters go to 0. State goes to IDLE.
  - cpu_ready=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0.
  - Data arrays are not cleared.
  - Reset during a WB or FILL aborts the burst. mem_req drops the next cycle, and any late mem_ack is ignored.
- FSM states:
  - IDLE: on cpu_req, latch addr/we/wdata, go to TAG.
  - TAG: compare the latched tag against both ways of the indexed set.
    - Hit: go to RESP. A hit in more than one way cannot occur.
    - Miss: select victim = an invalid way if one exists (way0 preferred), else the LRU way. Go to WB if the victim is valid and dirty, else FILL.
  - WB: issue WORDS memory writes, word 0 first.
    - Address = {victim tag, index, word#, 2'b00}.
    - Advance to the next word on mem_ack. After the last ack, go to FILL.
  - FILL: issue WORDS memory reads of the latched line base, word 0 first.
    - Write mem_rdata into the victim way on each ack.
    - On the last ack: set valid=1, dirty=0, tag=latched tag. Go to TAG.
  - RESP: assert cpu_ready for exactly one cycle, then go to IDLE.
    - Load: cpu_rdata = the hit word.
    - Store: write cpu_wdata into the word and set dirty=1. The write is visible to the next access.
    - LRU of the set = the way not hit.
- Latency:
  - Hit: cpu_req seen in IDLE at cycle N; cpu_ready at cycle N+2.
  - Clean miss: N+2 + WORDS memory transactions + 1 (re-TAG) cycles.
  - Dirty miss: additionally WORDS write transactions.
- Memory handshake:
  - mem_req rises the cycle after the state is entered and stays high with stable address/data until mem_ack.
  - mem_req drops in the ack cycle and is re-raised on the following cycle for the next word. This gives at least one idle cycle between words.
  - mem_ack while mem_req=0 is ignored.
- Counters:
  - hit_count increments once per TAG hit that occurs before any refill.
  - miss_count increments once per miss detected on first TAG entry.
  - The re-TAG after FILL counts neither.
  - Both saturate at all-ones.
- cpu_req deasserted mid-operation is a protocol violation. The cache completes the operation anyway and pulses cpu_ready.
- Back-to-back: cpu_req held high after cpu_ready is treated as a new request captured in IDLE the next cycle.

Decomposition:
- Package cache_pkg:
  - state enum (IDLE, TAG, WB, FILL, RESP);
  - functions for the OFF_W/IDX_W/TAG_W log2 derivations;
  - the address field-extract helpers.
- One natural sub-module: cache_way, holding the tag, valid and dirty arrays plus the data array, with read-index/compare outputs. It is instantiated twice.

Test Plan:
- Run with SETS=4, WORDS=4, memory model ack latency 3.
- Cold load at 0x0000_0040 (mem[0x40..0x4C] = 1,2,3,4): exactly 4 memory reads at 0x40, 0x44, 0x48, 0x4C, then cpu_rdata=1. miss_count=1.
- Load 0x0000_0048 next: cpu_ready exactly 2 cycles after req, rdata=3, no mem_req. hit_count=1.
- Store 0xDEADBEEF at 0x44, then load 0x44: rdata=0xDEADBEEF, no memory traffic, line dirty.
- Fill way1 of the same set via 0x0000_0140, touch 0x140, then load 0x0000_0240:
  - the dirty 0x40 line is evicted (LRU);
  - 4 writes at 0x40..0x4C, with mem[0x44]=0xDEADBEEF;
  - then 4 reads at 0x240..0x24C.
- Assert rst during the second FILL word:
  - next cycle mem_req=0 and cpu_ready=0;
  - a subsequent load of 0x40 misses (valid cleared);
  - counters are 0 before it.
- Force hit_count to all-ones (CNT_W=4 build, 16 hits): stays 0xF.
